// File: rtl/udp_tx.sv
// udp_tx: UDP transmit engine that buffers a payload, builds the UDP header and streams the frame to ip_tx.
// Optional feature macro: UDP_TX_CHECKSUM_EN (computes the checksum; when undefined the checksum field is 0x0000).
module udp_tx #(
    parameter int MAX_PAYLOAD = 1472,
    parameter int RAM_AW      = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              app_ram_wr_en,
    input  logic [RAM_AW-1:0] app_ram_wr_addr,
    input  logic [7:0]        app_ram_wr_data,
    input  logic              udp_send_req,
    input  logic [15:0]       udp_send_length,
    input  logic [15:0]       src_port,
    input  logic [15:0]       dest_port,
    input  logic [31:0]       ip_src_addr,
    input  logic [31:0]       ip_dest_addr,
    output logic              udp_send_busy,
    output logic              udp_send_done,
    output logic              udp_send_err,
    output logic              udp_tx_ready,
    output logic [15:0]       udp_tx_length,
    input  logic              ip_tx_ack,
    output logic [7:0]        udp_tx_data,
    output logic              udp_tx_data_valid,
    output logic              udp_tx_end
);

    typedef enum logic [2:0] {
        IDLE,
`ifdef UDP_TX_CHECKSUM_EN
        CHECKSUM,
`endif
        WAIT_ACK,
        SEND_HEAD,
        SEND_DATA,
        DONE
    } state_t;

    state_t            state;
    logic [7:0]        mem [0:(1<<RAM_AW)-1];
    logic [7:0]        ram_q;
    logic [RAM_AW-1:0] rd_addr;
    logic [15:0]       len;
    logic [15:0]       sport;
    logic [15:0]       dport;
    logic [15:0]       csum;
    logic [15:0]       pay_cnt;
    logic [3:0]        hcnt;
    logic [7:0]        head_byte;
    logic [7:0]        next_head;
    logic              pay_sel;
    logic              len_ok;
    logic [15:0]       req_len8;

    assign len_ok   = (udp_send_length != 16'd0) && (udp_send_length <= 16'(MAX_PAYLOAD));
    assign req_len8 = udp_send_length + 16'd8;

    // Payload bytes come straight from the buffer read register, header bytes from head_byte.
    assign udp_tx_data = pay_sel ? ram_q : head_byte;

`ifdef UDP_TX_CHECKSUM_EN
    logic [31:0] acc;
    logic [31:0] hdr_sum;
    logic [31:0] acc_fold;
    logic [15:0] csum_calc;
    logic [15:0] rd_cnt;
    logic        pend;
    logic        pend_odd;
    logic        folded;

    // Pseudo-header plus UDP header words, loaded into the accumulator when the request is accepted.
    assign hdr_sum = {16'd0, ip_src_addr[31:16]} + {16'd0, ip_src_addr[15:0]}
                   + {16'd0, ip_dest_addr[31:16]} + {16'd0, ip_dest_addr[15:0]}
                   + 32'h0000_0011 + {16'd0, req_len8} + {16'd0, req_len8}
                   + {16'd0, src_port} + {16'd0, dest_port};
    assign acc_fold  = {16'd0, acc[31:16]} + {16'd0, acc[15:0]};
    assign csum_calc = (acc_fold[15:0] == 16'hFFFF) ? 16'hFFFF : ~acc_fold[15:0];
`else
    logic unused_ip;
    assign unused_ip = ^{ip_src_addr, ip_dest_addr};
`endif

    always_comb begin
        rd_addr = pay_cnt[RAM_AW-1:0];
`ifdef UDP_TX_CHECKSUM_EN
        if (state == CHECKSUM) rd_addr = rd_cnt[RAM_AW-1:0];
`endif
    end

    always_comb begin
        case (hcnt[2:0])
            3'd1:    next_head = sport[7:0];
            3'd2:    next_head = dport[15:8];
            3'd3:    next_head = dport[7:0];
            3'd4:    next_head = udp_tx_length[15:8];
            3'd5:    next_head = udp_tx_length[7:0];
            3'd6:    next_head = csum[15:8];
            3'd7:    next_head = csum[7:0];
            default: next_head = sport[15:8];
        endcase
    end

    // The buffer is deliberately not reset so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (app_ram_wr_en && !udp_send_busy) mem[app_ram_wr_addr] <= app_ram_wr_data;
        ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            udp_send_busy     <= 1'b0;
            udp_send_done     <= 1'b0;
            udp_send_err      <= 1'b0;
            udp_tx_ready      <= 1'b0;
            udp_tx_length     <= 16'd0;
            udp_tx_data_valid <= 1'b0;
            udp_tx_end        <= 1'b0;
            len               <= 16'd0;
            sport             <= 16'd0;
            dport             <= 16'd0;
            csum              <= 16'd0;
            pay_cnt           <= 16'd0;
            hcnt              <= 4'd0;
            head_byte         <= 8'd0;
            pay_sel           <= 1'b0;
`ifdef UDP_TX_CHECKSUM_EN
            acc               <= 32'd0;
            rd_cnt            <= 16'd0;
            pend              <= 1'b0;
            pend_odd          <= 1'b0;
            folded            <= 1'b0;
`endif
        end else begin
            udp_send_done <= 1'b0;
            udp_send_err  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (udp_send_req) begin
                        if (len_ok) begin
                            udp_send_busy <= 1'b1;
                            len           <= udp_send_length;
                            udp_tx_length <= req_len8;
                            sport         <= src_port;
                            dport         <= dest_port;
                            pay_cnt       <= 16'd0;
`ifdef UDP_TX_CHECKSUM_EN
                            state         <= CHECKSUM;
                            acc           <= hdr_sum;
                            rd_cnt        <= 16'd0;
                            pend          <= 1'b0;
                            folded        <= 1'b0;
`else
                            state         <= WAIT_ACK;
                            csum          <= 16'd0;
                            udp_tx_ready  <= 1'b1;
`endif
                        end else begin
                            udp_send_err <= 1'b1;
                        end
                    end
                end
`ifdef UDP_TX_CHECKSUM_EN
                // Even payload bytes land in the high half of a word, odd bytes in the low half.
                CHECKSUM: begin
                    if (rd_cnt != len) rd_cnt <= rd_cnt + 16'd1;
                    pend     <= (rd_cnt != len);
                    pend_odd <= rd_cnt[0];
                    if (pend) begin
                        acc <= acc + (pend_odd ? {24'd0, ram_q} : {16'd0, ram_q, 8'd0});
                    end else if (rd_cnt == len) begin
                        if (!folded) begin
                            acc    <= acc_fold;
                            folded <= 1'b1;
                        end else begin
                            csum         <= csum_calc;
                            udp_tx_ready <= 1'b1;
                            state        <= WAIT_ACK;
                        end
                    end
                end
`endif
                WAIT_ACK: begin
                    if (ip_tx_ack) begin
                        udp_tx_ready      <= 1'b0;
                        udp_tx_data_valid <= 1'b1;
                        head_byte         <= next_head;
                        hcnt              <= 4'd1;
                        state             <= SEND_HEAD;
                    end
                end
                SEND_HEAD: begin
                    if (hcnt == 4'd8) begin
                        head_byte  <= 8'd0;
                        pay_sel    <= 1'b1;
                        pay_cnt    <= 16'd1;
                        udp_tx_end <= (len == 16'd1);
                        state      <= SEND_DATA;
                    end else begin
                        head_byte <= next_head;
                        hcnt      <= hcnt + 4'd1;
                    end
                end
                SEND_DATA: begin
                    if (pay_cnt == len) begin
                        udp_tx_data_valid <= 1'b0;
                        udp_tx_end        <= 1'b0;
                        pay_sel           <= 1'b0;
                        udp_send_busy     <= 1'b0;
                        udp_send_done     <= 1'b1;
                        state             <= DONE;
                    end else begin
                        pay_cnt    <= pay_cnt + 16'd1;
                        udp_tx_end <= ((pay_cnt + 16'd1) == len);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: table-driven bench for udp_tx with an expected-byte queue scoreboard.
// Expected checksum and ready latency follow whether UDP_TX_CHECKSUM_EN is defined.
module tb_udp_tx;

    typedef struct {
        int          n;
        logic [63:0] pay;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [31:0] sa;
        logic [31:0] da;
        logic        exp_err;
        logic        csum_known;
        logic [15:0] exp_csum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        app_ram_wr_en;
    logic [10:0] app_ram_wr_addr;
    logic [7:0]  app_ram_wr_data;
    logic        udp_send_req;
    logic [15:0] udp_send_length;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [31:0] ip_src_addr;
    logic [31:0] ip_dest_addr;
    logic        udp_send_busy;
    logic        udp_send_done;
    logic        udp_send_err;
    logic        udp_tx_ready;
    logic [15:0] udp_tx_length;
    logic        ip_tx_ack;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_data_valid;
    logic        udp_tx_end;

    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[8];
    logic [7:0]  bmem [2048];
    logic [7:0]  exp_q[$];

    udp_tx dut (
        .clk(clk), .rst(rst),
        .app_ram_wr_en(app_ram_wr_en), .app_ram_wr_addr(app_ram_wr_addr), .app_ram_wr_data(app_ram_wr_data),
        .udp_send_req(udp_send_req), .udp_send_length(udp_send_length),
        .src_port(src_port), .dest_port(dest_port),
        .ip_src_addr(ip_src_addr), .ip_dest_addr(ip_dest_addr),
        .udp_send_busy(udp_send_busy), .udp_send_done(udp_send_done), .udp_send_err(udp_send_err),
        .udp_tx_ready(udp_tx_ready), .udp_tx_length(udp_tx_length), .ip_tx_ack(ip_tx_ack),
        .udp_tx_data(udp_tx_data), .udp_tx_data_valid(udp_tx_data_valid), .udp_tx_end(udp_tx_end)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] payByte(input vec_t v, input int k);
        logic [63:0] p;
        p = v.pay;
        if (k < 8) return p[63 - 8*k -: 8];
        return 8'(k) ^ 8'h5C;
    endfunction

    // Reference checksum: plain one's-complement sum of 16-bit words, folded until no carry remains.
    function automatic logic [15:0] modelChecksum(input vec_t v);
        logic [31:0] s;
        logic [15:0] l;
        logic [7:0]  lo;
        l = 16'(v.n + 8);
        s = 32'(v.sa[31:16]) + 32'(v.sa[15:0]) + 32'(v.da[31:16]) + 32'(v.da[15:0])
          + 32'h11 + 32'(l) + 32'(v.sp) + 32'(v.dp) + 32'(l);
        for (int i = 0; i < v.n; i += 2) begin
            lo = (i + 1 < v.n) ? bmem[i + 1] : 8'h00;
            s = s + 32'({bmem[i], lo});
        end
        while (s[31:16] != 16'd0) s = 32'(s[31:16]) + 32'(s[15:0]);
        return (s[15:0] == 16'hFFFF) ? 16'hFFFF : ~s[15:0];
    endfunction

    task automatic loadPayload(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            app_ram_wr_en   = 1'b1;
            app_ram_wr_addr = 11'(k);
            app_ram_wr_data = payByte(v, k);
            bmem[k]         = payByte(v, k);
        end
        @(negedge clk);
        app_ram_wr_en = 1'b0;
    endtask

    task automatic driveRequest(input vec_t v);
        @(negedge clk);
        udp_send_req    = 1'b1;
        udp_send_length = 16'(v.n);
        src_port        = v.sp;
        dest_port       = v.dp;
        ip_src_addr     = v.sa;
        ip_dest_addr    = v.da;
        @(negedge clk);
        udp_send_req    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int ack_delay);
        int          lat;
        int          nvalid;
        int          cyc;
        int          last_valid_cyc;
        int          done_cyc;
        int          exp_lat;
        logic [15:0] ck;
        logic [15:0] l8;
        logic [7:0]  b;
        logic        done_seen;
        logic        gap;
        logic        was_valid;
        logic        bad_hold;
        logic        busy_at_done;

        if (!v.exp_err) loadPayload(v);
        l8 = 16'(v.n + 8);
`ifdef UDP_TX_CHECKSUM_EN
        ck      = v.csum_known ? v.exp_csum : modelChecksum(v);
        exp_lat = v.n + 4;
`else
        ck      = 16'h0000;
        exp_lat = 1;
`endif
        exp_q.delete();
        if (!v.exp_err) begin
            exp_q.push_back(v.sp[15:8]); exp_q.push_back(v.sp[7:0]);
            exp_q.push_back(v.dp[15:8]); exp_q.push_back(v.dp[7:0]);
            exp_q.push_back(l8[15:8]);   exp_q.push_back(l8[7:0]);
            exp_q.push_back(ck[15:8]);   exp_q.push_back(ck[7:0]);
            for (int k = 0; k < v.n; k++) exp_q.push_back(bmem[k]);
        end
        ip_tx_ack = (ack_delay == 0);
        driveRequest(v);

        if (v.exp_err) begin
            checkOutput("err_pulse", 32'(udp_send_err), 1);
            checkOutput("err_busy", 32'(udp_send_busy), 0);
            @(negedge clk);
            checkOutput("err_single_cycle", 32'(udp_send_err), 0);
            bad_hold = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (udp_tx_ready || udp_send_busy || udp_tx_data_valid) bad_hold = 1'b1;
                @(negedge clk);
            end
            checkOutput("err_no_frame", 32'(bad_hold), 0);
            return;
        end

        checkOutput("busy_rise", 32'(udp_send_busy), 1);
        lat = 1;
        while (!udp_tx_ready && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ready_latency", lat, exp_lat);
        checkOutput("tx_length", 32'(udp_tx_length), 32'(l8));

        // Hold off the grant; a second request and a buffer write land while busy.
        if (ack_delay > 0) begin
            bad_hold = 1'b0;
            for (int i = 0; i < ack_delay; i++) begin
                if (!udp_tx_ready || udp_tx_data_valid || udp_send_err || !udp_send_busy) bad_hold = 1'b1;
                if (i == 5) begin
                    udp_send_req    = 1'b1;
                    udp_send_length = 16'd2;
                    src_port        = 16'h1234;
                    app_ram_wr_en   = 1'b1;
                    app_ram_wr_addr = 11'd0;
                    app_ram_wr_data = 8'hFF;
                end
                if (i == 6) begin
                    udp_send_req  = 1'b0;
                    app_ram_wr_en = 1'b0;
                end
                @(negedge clk);
            end
            checkOutput("ack_hold", 32'(bad_hold), 0);
            ip_tx_ack = 1'b1;
        end

        @(negedge clk);
        if (ack_delay > 0) ip_tx_ack = 1'b0;
        checkOutput("ready_fall", 32'(udp_tx_ready), 0);
        checkOutput("first_valid", 32'(udp_tx_data_valid), 1);

        nvalid = 0; cyc = 0; done_seen = 1'b0; gap = 1'b0; was_valid = 1'b1;
        last_valid_cyc = -100; done_cyc = -50; busy_at_done = 1'b1;
        while (!done_seen && cyc < v.n + 40) begin
            if (udp_tx_data_valid) begin
                if (nvalid > 0 && !was_valid) gap = 1'b1;
                if (exp_q.size() == 0) begin
                    checkOutput("extra_byte", nvalid + 1, v.n + 8);
                end else begin
                    b = exp_q.pop_front();
                    checkOutput("stream_byte", 32'(udp_tx_data), 32'(b));
                    checkOutput("end_flag", 32'(udp_tx_end), 32'(exp_q.size() == 0));
                end
                nvalid++;
                last_valid_cyc = cyc;
            end else if (udp_send_done) begin
                done_seen    = 1'b1;
                done_cyc     = cyc;
                busy_at_done = udp_send_busy;
            end
            was_valid = udp_tx_data_valid;
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("valid_count", nvalid, v.n + 8);
        checkOutput("valid_contiguous", 32'(gap), 0);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("done_timing", done_cyc - last_valid_cyc, 1);
        checkOutput("done_busy_low", 32'(busy_at_done), 0);

        if (ack_delay > 0) begin
            bad_hold = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (udp_tx_ready || udp_send_busy || udp_tx_data_valid) bad_hold = 1'b1;
            end
            checkOutput("ignored_request", 32'(bad_hold), 0);
        end
    endtask

    initial begin
        int nv;
        int cyc;

        vecs[0] = '{4,    64'h01020304_00000000, 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 1'b0, 1'b1, 16'h3952};
        vecs[1] = '{3,    64'hAABBCC00_00000000, 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 1'b0, 1'b1, 16'hC69D};
        vecs[2] = '{6,    64'h01020304_394E0000, 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 1'b0, 1'b1, 16'hFFFF};
        vecs[3] = '{0,    64'h0,                 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{1473, 64'h0,                 16'h1F90, 16'h1F91, 32'hC0A8010A, 32'hC0A80102, 1'b1, 1'b0, 16'h0000};
        vecs[5] = '{1,    64'h5A000000_00000000, 16'h0035, 16'hC000, 32'h0A000001, 32'h0A0000FE, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{8,    64'h00112233_44556677, 16'h8000, 16'h0050, 32'hAC100001, 32'hAC10FFFF, 1'b0, 1'b0, 16'h0000};
        vecs[7] = '{1472, 64'hDEADBEEF_CAFE1234, 16'hFFFF, 16'h0001, 32'h7F000001, 32'h7F000001, 1'b0, 1'b0, 16'h0000};

        rst = 1'b1;
        app_ram_wr_en = 1'b0; app_ram_wr_addr = 11'd0; app_ram_wr_data = 8'd0;
        udp_send_req = 1'b0; udp_send_length = 16'd0; src_port = 16'd0; dest_port = 16'd0;
        ip_src_addr = 32'd0; ip_dest_addr = 32'd0; ip_tx_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_stream", {23'd0, udp_tx_data, udp_tx_data_valid}, 0);
        checkOutput("reset_ctrl", {udp_tx_length, 11'd0, udp_send_busy, udp_send_done, udp_send_err,
                                   udp_tx_ready, udp_tx_end}, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], 0);

        $display("[TB] delayed grant with requests and writes while busy");
        applyStimulus(vecs[1], 20);

        // Reset lands while payload byte 2 of a 4-byte frame is on the bus.
        $display("[TB] reset mid-frame");
        loadPayload(vecs[0]);
        ip_tx_ack = 1'b1;
        driveRequest(vecs[0]);
        nv = 0; cyc = 0;
        while (nv < 11 && cyc < 200) begin
            if (udp_tx_data_valid) nv++;
            if (nv < 11) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("pre_reset_byte", 32'(udp_tx_data), 32'h03);
        #1 rst = 1'b1;
        #1;
        checkOutput("midreset_stream", {22'd0, udp_tx_data, udp_tx_data_valid, udp_tx_end}, 0);
        checkOutput("midreset_ctrl", {27'd0, udp_send_busy, udp_send_done, udp_send_err, udp_tx_ready, 1'b0}, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(vecs[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
